rsa_modexp_ctrl: RTL and testbench
==================================

Name: rsa_modexp_ctrl

Overview:
- Sequencer for RSA modular exponentiation: computes result = data^key mod n by left-to-right square-and-multiply.
- Owns no arithmetic. It issues every (a*b) mod n operation to an external modular-multiply unit over a req/ack handshake.
- Sits between the top-level start/done interface and the multiplier+modulo datapath. It replaces ad-hoc counter/mux sequencing with an explicit FSM.

Parameters:
- W, 6, operand width of data, n and result.
- KW, 6, key width; also the number of squaring steps.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request a new exponentiation; sampled only in IDLE.
- data  in  W  base; latched on accepted start.
- key  in  KW  exponent; latched on accepted start.
- n  in  W  modulus; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when result is valid.
- err  out  1  one-cycle pulse together with done when n==0.
- result  out  W  registered result; holds its value until the next done.
- mm_req  out  1  modular-multiply request; held high until ack.
- mm_a  out  W  multiply operand A; stable while mm_req=1.
- mm_b  out  W  multiply operand B; stable while mm_req=1.
- mm_n  out  W  modulus; stable while mm_req=1.
- mm_ack  in  1  one-cycle pulse; mm_res is valid in the same cycle.
- mm_res  in  W  (mm_a*mm_b) mod mm_n.

Behaviour:
- Reset: state=IDLE; busy, done, err, mm_req and result all 0; internal regs cleared. Reset mid-operation aborts at once, and mm_req drops asynchronously.
- Internal regs: m_q, k_q, n_q (latched operands), r_q (accumulator, W bits), idx (0..KW-1).
- IDLE: start=1 -> LOAD. Latch data, key and n; r_q=1; idx=KW-1.
- LOAD, in priority order:
  - n_q==0 -> DONE with err=1 and result=0.
  - k_q==0 -> DONE with result=(n_q==1)?0:1.
  - else -> SQR.
  - No mm transaction is issued for the two special cases.
- SQR: mm_req=1, mm_a=mm_b=r_q, mm_n=n_q. On mm_ack: r_q<=mm_res, then go to MUL if k_q[idx]==1, else NEXT.
- MUL: mm_req=1, mm_a=r_q, mm_b=m_q. On mm_ack: r_q<=mm_res -> NEXT.
- NEXT: idx==0 -> DONE; else idx<=idx-1 -> SQR.
- DONE: result<=r_q (or the special value), done=1 (err as above) for exactly one cycle -> IDLE.
- Handshake rules:
  - mm_ack is honoured only when mm_req=1; a stray ack is ignored.
  - Earliest ack is the cycle after mm_req rises.
  - A new transaction may start the cycle after an ack, so mm_req may stay high across back-to-back transactions, with operands changing at the ack edge.
- Op count: exactly KW squarings + popcount(key) multiplies. Leading-zero bits are still squared (1*1).
- Latency, start edge to done cycle: 1 (LOAD) + Σ(L_i+1) + KW (NEXT) + 1, where L_i is the req-to-ack delay of each op.
- start while busy: ignored, no effect on latched operands.
- data>=n is legal; reduction happens in the mm unit.
- All arithmetic lives in the mm unit. The controller does no width growth.

Decomposition:
- Shared package rsa_pkg holds:
  - state enum {IDLE, LOAD, SQR, MUL, NEXT, DONE};
  - localparams RSA_W=6 and RSA_KW=6 as the defaults for W and KW.
- No sub-module needed; the idx down-counter stays inline.
- The bench supplies a behavioural mm unit with programmable latency.

Test Plan:
- data=5, key=3, n=14, mm latency 1 -> result=13; 8 mm transactions; done one-cycle pulse; busy high from LOAD through DONE.
- data=7, key=13, n=33, random mm latency 1..5 -> result=13; 9 transactions; operands stable while mm_req=1; stray mm_ack in IDLE ignored.
- key=0: n=7 -> result=1; n=1 -> result=0. Both with no mm_req and done 2 cycles after the start edge.
- n=0, data=3, key=5 -> done with err=1, result=0, no mm_req.
- start re-pulsed mid-run with different operands -> ignored; first result 13 delivered (data=5, key=3, n=14), then a new start is accepted.
- reset_n low during a MUL wait -> mm_req, busy and result drop to 0 immediately; a fresh run after release gives the correct result.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and default sizes for the RSA modular-exponentiation sequencer.
package rsa_pkg;

  localparam int RSA_W  = 6;
  localparam int RSA_KW = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SQR  = 3'd2,
    MUL  = 3'd3,
    NEXT = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer; every (a*b) mod n is delegated
// to an external modular-multiply unit over a req/ack handshake.
module rsa_modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int W  = RSA_W,
  parameter int KW = RSA_KW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [W-1:0]  data,
  input  logic [KW-1:0] key,
  input  logic [W-1:0]  n,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  result,
  output logic          mm_req,
  output logic [W-1:0]  mm_a,
  output logic [W-1:0]  mm_b,
  output logic [W-1:0]  mm_n,
  input  logic          mm_ack,
  input  logic [W-1:0]  mm_res
);

  localparam int            IW      = (KW > 1) ? $clog2(KW) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(KW - 1);
  localparam logic [W-1:0]  ONE     = W'(1);

  state_t        state_q;
  logic [W-1:0]  m_q;
  logic [W-1:0]  n_q;
  logic [W-1:0]  r_q;
  logic [KW-1:0] k_q;
  logic [IW-1:0] idx_q;

  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [W-1:0]  result_q;
  logic          mm_req_q;
  logic [W-1:0]  mm_a_q;
  logic [W-1:0]  mm_b_q;
  logic [W-1:0]  mm_n_q;

  logic          ack_s;
  logic          key_bit_s;

  // An ack only counts while a request is outstanding; stray pulses are dropped.
  assign ack_s     = mm_ack & mm_req_q;
  assign key_bit_s = k_q[idx_q];

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign mm_req = mm_req_q;
  assign mm_a   = mm_a_q;
  assign mm_b   = mm_b_q;
  assign mm_n   = mm_n_q;

  // Sequencer state, operand latches, accumulator and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      m_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      k_q      <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      mm_req_q <= 1'b0;
      mm_a_q   <= '0;
      mm_b_q   <= '0;
      mm_n_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (start) begin
            m_q     <= data;
            k_q     <= key;
            n_q     <= n;
            r_q     <= ONE;
            idx_q   <= IDX_TOP;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end else begin
            state_q <= IDLE;
          end
        end

        // Degenerate modulus / exponent finish without touching the mm unit.
        LOAD: begin
          if (n_q == '0) begin
            result_q <= '0;
            err_q    <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (k_q == '0) begin
            result_q <= (n_q == ONE) ? '0 : ONE;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            mm_req_q <= 1'b1;
            mm_a_q   <= r_q;
            mm_b_q   <= r_q;
            mm_n_q   <= n_q;
            state_q  <= SQR;
          end
        end

        // Back-to-back into MUL keeps mm_req high; operands switch at the ack edge.
        SQR: begin
          if (ack_s) begin
            r_q <= mm_res;
            if (key_bit_s) begin
              mm_a_q  <= mm_res;
              mm_b_q  <= m_q;
              state_q <= MUL;
            end else begin
              mm_req_q <= 1'b0;
              state_q  <= NEXT;
            end
          end else begin
            state_q <= SQR;
          end
        end

        MUL: begin
          if (ack_s) begin
            r_q      <= mm_res;
            mm_req_q <= 1'b0;
            state_q  <= NEXT;
          end else begin
            state_q <= MUL;
          end
        end

        NEXT: begin
          if (idx_q == '0) begin
            result_q <= r_q;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            idx_q    <= idx_q - IW'(1);
            mm_req_q <= 1'b1;
            mm_a_q   <= r_q;
            mm_b_q   <= r_q;
            state_q  <= SQR;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          err_q    <= 1'b0;
          mm_req_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Randomized bench for rsa_modexp_ctrl with a behavioural mm unit and a
// plain-arithmetic modexp reference model.
module tb_rsa_modexp_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [5:0] data;
  logic [5:0] key;
  logic [5:0] n;
  logic       busy;
  logic       done;
  logic       err;
  logic [5:0] result;
  logic       mm_req;
  logic [5:0] mm_a;
  logic [5:0] mm_b;
  logic [5:0] mm_n;
  logic       mm_ack;
  logic [5:0] mm_res;

  int total = 0;
  int bad   = 0;

  // mm unit model state
  int         max_lat   = 1;
  bit         stray_req = 1'b0;
  bit         pend      = 1'b0;
  int         cnt       = 0;
  int         n_ops     = 0;
  int         lat_sum   = 0;
  bit         stable    = 1'b1;
  logic [5:0] a0, b0, n0;

  rsa_modexp_ctrl #(.W(6), .KW(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .data(data), .key(key), .n(n),
    .busy(busy), .done(done), .err(err), .result(result),
    .mm_req(mm_req), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
    .mm_ack(mm_ack), .mm_res(mm_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_modexp(input int d, input int k, input int nn, output int e);
    int r;
    e = 0;
    if (nn == 0) begin
      e = 1;
      return 0;
    end
    if (k == 0) return (nn == 1) ? 0 : 1;
    r = 1;
    for (int i = 5; i >= 0; i--) begin
      r = (r * r) % nn;
      if (((k >> i) & 1) == 1) r = (r * d) % nn;
    end
    return r;
  endfunction

  // Behavioural modular multiplier: random latency, operand-stability watch.
  initial begin
    mm_ack = 1'b0;
    mm_res = '0;
    forever begin
      @(negedge clk);
      mm_ack = 1'b0;
      if (!reset_n) begin
        pend = 1'b0;
      end else if (pend) begin
        if (!(mm_req && mm_a == a0 && mm_b == b0 && mm_n == n0)) stable = 1'b0;
        cnt--;
        if (cnt == 0) begin
          check_eq("op_stable", int'(stable), 1);
          mm_res = (n0 == 6'd0) ? 6'd0 : 6'((int'(a0) * int'(b0)) % int'(n0));
          mm_ack = 1'b1;
          pend   = 1'b0;
        end
      end else if (mm_req) begin
        pend    = 1'b1;
        cnt     = $urandom_range(max_lat, 1);
        lat_sum += cnt + 1;
        n_ops++;
        a0      = mm_a;
        b0      = mm_b;
        n0      = mm_n;
        stable  = 1'b1;
      end else if (stray_req) begin
        mm_res    = 6'($urandom_range(63, 0));
        mm_ack    = 1'b1;
        stray_req = 1'b0;
      end
    end
  end

  task automatic run_case(input string tag, input logic [5:0] d, input logic [5:0] k,
                          input logic [5:0] nn, input int ml, input bit repulse);
    int exp_res, exp_err, exp_ops, exp_lat, cyc, done_cyc;
    bit busy_ok;
    exp_res = ref_modexp(int'(d), int'(k), int'(nn), exp_err);
    exp_ops = (nn == 6'd0 || k == 6'd0) ? 0 : 6 + $countones(k);
    max_lat = ml;
    n_ops   = 0;
    lat_sum = 0;
    @(negedge clk);
    data  = d;
    key   = k;
    n     = nn;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    cyc      = 1;
    busy_ok  = 1'b1;
    done_cyc = 0;
    while (done_cyc == 0 && cyc < 400) begin
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        done_cyc = cyc;
      end else begin
        if (repulse && cyc == 3) begin
          start = 1'b1;
          data  = 6'd9;
          key   = 6'd63;
          n     = 6'd20;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start   = 1'b0;
    exp_lat = (exp_ops == 0) ? 2 : 1 + lat_sum + 6 + 1;
    check_eq({tag, "_done_seen"}, int'(done_cyc != 0), 1);
    check_eq({tag, "_result"}, int'(result), exp_res);
    check_eq({tag, "_err"}, int'(err), exp_err);
    check_eq({tag, "_ops"}, n_ops, exp_ops);
    check_eq({tag, "_latency"}, done_cyc, exp_lat);
    check_eq({tag, "_busy_run"}, int'(busy_ok), 1);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, int'(done), 0);
    check_eq({tag, "_err_pulse"}, int'(err), 0);
    check_eq({tag, "_busy_idle"}, int'(busy), 0);
    check_eq({tag, "_result_hold"}, int'(result), exp_res);
  endtask

  initial begin
    int  waited;
    bit  found;
    reset_n = 1'b0;
    start   = 1'b0;
    data    = '0;
    key     = '0;
    n       = '0;
    #12;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_mm_req", int'(mm_req), 0);
    check_eq("rst_result", int'(result), 0);
    @(negedge clk);
    reset_n = 1'b1;

    run_case("basic", 6'd5, 6'd3, 6'd14, 1, 1'b0);

    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("stray_mm_req", int'(mm_req), 0);
    check_eq("stray_busy", int'(busy), 0);
    check_eq("stray_done", int'(done), 0);
    check_eq("stray_result", int'(result), 13);

    run_case("randlat", 6'd7, 6'd13, 6'd33, 5, 1'b0);
    run_case("key0_n7", 6'd4, 6'd0, 6'd7, 3, 1'b0);
    run_case("key0_n1", 6'd4, 6'd0, 6'd1, 3, 1'b0);
    run_case("n0", 6'd3, 6'd5, 6'd0, 3, 1'b0);
    run_case("repulse", 6'd5, 6'd3, 6'd14, 2, 1'b1);
    run_case("after_repulse", 6'd7, 6'd13, 6'd33, 1, 1'b0);

    // Abort during the first multiply (6th op of key=3) and recover.
    max_lat = 5;
    n_ops   = 0;
    @(negedge clk);
    data  = 6'd5;
    key   = 6'd3;
    n     = 6'd14;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    found  = 1'b0;
    waited = 0;
    while (!found && waited < 300) begin
      if (n_ops == 6 && pend) found = 1'b1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
    check_eq("abort_reached_mul", int'(found), 1);
    check_eq("abort_mul_b", int'(mm_b), 5);
    #2 reset_n = 1'b0;
    #1;
    check_eq("abort_mm_req", int'(mm_req), 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_result", int'(result), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_case("post_abort", 6'd5, 6'd3, 6'd14, 3, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_case("random", 6'($urandom_range(63, 0)), 6'($urandom_range(63, 0)),
               6'($urandom_range(63, 0)), $urandom_range(4, 1), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
